// File: rtl/uart16550_rx.sv
// UART16550 serial receiver: oversamples sin at 16x baud, deserialises one
// character per frame and writes {bi, fe, pe, d[7:0]} to the Rx FIFO.
module uart16550_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        baud16_i,
    input  logic        sin_i,
    input  logic [1:0]  wls_i,
    input  logic        pen_i,
    input  logic        eps_i,
    input  logic        stick_parity_i,
    output logic [10:0] rx_d_o,
    output logic        rx_we_o,
    output logic        busy_o,
    output logic        sin_sync_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } state_t;

    // Expected parity bit for the received data under the latched frame settings.
    function automatic logic exp_parity(input logic [7:0] d, input logic eps, input logic stick);
        logic x;
        x = ^d;
        if (stick) begin
            exp_parity = ~eps;
        end else if (eps) begin
            exp_parity = x;
        end else begin
            exp_parity = ~x;
        end
    endfunction

    state_t                 state_r, state_nxt;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sin_s;
    logic [3:0]             tick_r;
    logic [2:0]             bit_r;
    logic [2:0]             last_bit_s;
    logic [7:0]             data_r;
    logic [1:0]             wls_r;
    logic                   pen_r, eps_r, stick_r;
    logic                   pe_r;
    logic                   zero_r;
    logic                   tick_clr_s, sample_s, latch_s, write_s;
    logic [10:0]            rx_d_r;
    logic                   rx_we_r;
    logic                   busy_r;

    assign sin_s      = sync_r[SYNC_STAGES-1];
    assign last_bit_s = {1'b0, wls_r} + 3'd4;

    // Metastability synchroniser for the asynchronous serial line, idles high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sin_i};
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state and datapath strobes; everything advances only on baud ticks.
    always_comb begin
        state_nxt  = state_r;
        tick_clr_s = 1'b0;
        sample_s   = 1'b0;
        latch_s    = 1'b0;
        write_s    = 1'b0;
        if (baud16_i) begin
            case (state_r)
                IDLE: begin
                    if (!sin_s) begin
                        state_nxt  = START;
                        tick_clr_s = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                START: begin
                    if (tick_r == 4'd7) begin
                        if (sin_s) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt  = DATA;
                            latch_s    = 1'b1;
                            tick_clr_s = 1'b1;
                        end
                    end else begin
                        state_nxt = START;
                    end
                end
                DATA: begin
                    if (tick_r == 4'd15) begin
                        sample_s = 1'b1;
                        if (bit_r == last_bit_s) begin
                            state_nxt = pen_r ? PARITY : STOP;
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        state_nxt = DATA;
                    end
                end
                PARITY: begin
                    if (tick_r == 4'd15) begin
                        sample_s  = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        state_nxt = PARITY;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a back-to-back start bit be caught.
                    if (tick_r == 4'd15) begin
                        sample_s  = 1'b1;
                        write_s   = 1'b1;
                        state_nxt = (zero_r && !sin_s) ? BRK_WAIT : IDLE;
                    end else begin
                        state_nxt = STOP;
                    end
                end
                BRK_WAIT: begin
                    if (sin_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BRK_WAIT;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Oversampling tick counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_r <= 4'd0;
        end else if (baud16_i) begin
            tick_r <= tick_clr_s ? 4'd0 : tick_r + 4'd1;
        end else begin
            tick_r <= tick_r;
        end
    end

    // Frame settings, shift data, parity error and all-zero (break) tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wls_r   <= 2'd0;
            pen_r   <= 1'b0;
            eps_r   <= 1'b0;
            stick_r <= 1'b0;
            data_r  <= 8'd0;
            bit_r   <= 3'd0;
            pe_r    <= 1'b0;
            zero_r  <= 1'b0;
        end else if (latch_s) begin
            wls_r   <= wls_i;
            pen_r   <= pen_i;
            eps_r   <= eps_i;
            stick_r <= stick_parity_i;
            data_r  <= 8'd0;
            bit_r   <= 3'd0;
            pe_r    <= 1'b0;
            zero_r  <= 1'b1;
        end else if (sample_s) begin
            zero_r <= zero_r & ~sin_s;
            if (state_r == DATA) begin
                data_r[bit_r] <= sin_s;
                bit_r         <= bit_r + 3'd1;
            end else if (state_r == PARITY) begin
                pe_r <= sin_s ^ exp_parity(data_r, eps_r, stick_r);
            end else begin
                pe_r <= pe_r;
            end
        end else begin
            zero_r <= zero_r;
        end
    end

    // Registered FIFO write port and busy flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_d_r  <= 11'd0;
            rx_we_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            rx_we_r <= write_s;
            busy_r  <= (state_nxt != IDLE);
            if (write_s) begin
                if (zero_r && !sin_s) begin
                    rx_d_r <= 11'h600;
                end else begin
                    rx_d_r <= {1'b0, ~sin_s, pe_r, data_r};
                end
            end else begin
                rx_d_r <= rx_d_r;
            end
        end
    end

    assign rx_d_o     = rx_d_r;
    assign rx_we_o    = rx_we_r;
    assign busy_o     = busy_r;
    assign sin_sync_o = sin_s;

endmodule

// File: tb/tb_uart16550_rx.sv
// Scoreboard bench for uart16550_rx: frames are pushed with their expected
// FIFO entry; a monitor pops and compares on every write strobe.
module tb_uart16550_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        baud16;
    logic        sin;
    logic [1:0]  wls;
    logic        pen, eps, stick;
    logic [10:0] rx_d;
    logic        rx_we, busy, sin_sync;

    int          div = 1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_exp;

    uart16550_rx #(.SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .baud16_i(baud16), .sin_i(sin),
        .wls_i(wls), .pen_i(pen), .eps_i(eps), .stick_parity_i(stick),
        .rx_d_o(rx_d), .rx_we_o(rx_we), .busy_o(busy), .sin_sync_o(sin_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    // Baud tick generator: one pulse every div clocks.
    initial begin
        int cnt = 0;
        baud16 = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt + 1 >= div) begin
                baud16 = 1'b1;
                cnt = 0;
            end else begin
                baud16 = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: every write strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (rx_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %03h expected none", rx_d);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_d", rx_d, mon_exp);
            end
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (baud16) k++;
        end
    endtask

    task automatic drive_bit(input logic b, input int ticks);
        @(negedge clk);
        sin = b;
        wait_ticks(ticks);
    endtask

    // Reference: expected entry from data, frame format, parity error flag and stop bit.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] w, input logic p,
                              input logic ep, input logic s, input logic perr,
                              input logic stop, input int gap);
        int          nb;
        logic [7:0]  d;
        logic        pxor, good_p, pbit, brk;
        nb     = int'(w) + 5;
        d      = data & 8'((1 << nb) - 1);
        pxor   = 1'($countones(d) % 2);
        good_p = s ? ~ep : (ep ? pxor : ~pxor);
        pbit   = good_p ^ perr;
        brk    = (d == 8'd0) && (!p || !pbit) && !stop;
        exp_q.push_back(brk ? 11'h600 : {1'b0, ~stop, p & perr, d});
        @(negedge clk);
        wls = w; pen = p; eps = ep; stick = s;
        drive_bit(1'b0, 16);
        wls = 2'($urandom_range(0, 3));
        pen = 1'($urandom_range(0, 1));
        eps = 1'($urandom_range(0, 1));
        stick = 1'($urandom_range(0, 1));
        for (int i = 0; i < nb; i++) drive_bit(d[i], 16);
        if (p) drive_bit(pbit, 16);
        drive_bit(stop, 16);
        if (!stop && gap < 24) gap = 24;
        if (gap > 0) drive_bit(1'b1, gap);
    endtask

    initial begin
        int bound;
        logic [1:0] rw;
        logic rp;
        rst = 1'b1; sin = 1'b1; wls = 2'b11; pen = 1'b0; eps = 1'b0; stick = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_d", rx_d, 11'h000);
        check("reset_rx_we", 11'(rx_we), 11'd0);
        check("reset_busy", 11'(busy), 11'd0);
        check("reset_sin_sync", 11'(sin_sync), 11'd1);
        rst = 1'b0;
        drive_bit(1'b1, 8);

        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20);
        @(negedge clk);
        check("busy_after_8n1", 11'(busy), 11'd0);
        send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 20);
        send_frame(8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24);

        // Break: 30 bit times low on an 8N1 line.
        @(negedge clk);
        wls = 2'b11; pen = 1'b0; eps = 1'b0; stick = 1'b0;
        exp_q.push_back(11'h600);
        drive_bit(1'b0, 30 * 16);
        @(negedge clk);
        check("busy_in_break", 11'(busy), 11'd1);
        drive_bit(1'b1, 8);
        @(negedge clk);
        check("busy_after_break", 11'(busy), 11'd0);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16);

        // Glitch shorter than half a bit.
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 24);
        @(negedge clk);
        check("busy_after_glitch", 11'(busy), 11'd0);
        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16);

        // Reset in the middle of data bit 3 of 0xFF.
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 16);
        drive_bit(1'b1, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_rx_d", rx_d, 11'h000);
        check("midreset_rx_we", 11'(rx_we), 11'd0);
        check("midreset_busy", 11'(busy), 11'd0);
        check("midreset_sin_sync", 11'(sin_sync), 11'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 16);
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16);

        // Randomised frames over formats, baud divisors and gaps.
        for (int n = 0; n < 40; n++) begin
            div = $urandom_range(1, 3);
            rw = 2'($urandom_range(0, 3));
            rp = 1'($urandom_range(0, 1));
            send_frame(8'($urandom), rw, rp, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), rp & 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) != 0),
                       $urandom_range(0, 1) * $urandom_range(1, 20));
        end
        drive_bit(1'b1, 20);

        bound = 0;
        while (exp_q.size() != 0 && bound < 2000) begin
            @(negedge clk);
            bound++;
        end
        check("scoreboard_drained", 11'(exp_q.size()), 11'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart16550_rx.md
Name: uart16550_rx

Overview:
- Serial receiver of the UART16550: deserialises the `sin` line into characters and writes one Rx-FIFO entry per frame.
- The entry is bi, fe, pe and an 8-bit data field, in the same layout as the package Rx FIFO data type.
- Sits between the modem-side input (after the loopback mux) and the Rx FIFO.
- Timing comes from the shared baud generator's 16x oversampling tick.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `sin` metastability synchroniser (minimum 2).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- baud16_i  input  1  one-cycle enable pulse at 16x the baud rate
- sin_i  input  1  serial data in, asynchronous, idle high
- wls_i  input  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
- pen_i  input  1  parity enable
- eps_i  input  1  even parity select
- stick_parity_i  input  1  stick parity
- rx_d_o  output  11  {bi, fe, pe, d[7:0]}
- rx_we_o  output  1  one-cycle write strobe to the Rx FIFO
- busy_o  output  1  frame in progress (any state other than IDLE)
- sin_sync_o  output  1  synchronised sin, for MSR/timeout logic

Behaviour:
- Reset: state=IDLE; rx_d_o=0; rx_we_o=0; busy_o=0; synchroniser and sin_sync_o preset to 1.
- Tick counting: the 4-bit tick counter, bit counter and state advance only on baud16_i cycles; all other cycles hold.
- State machine:
  - IDLE: on a baud16_i cycle with sin_sync=0, go to START and clear the counter.
  - START: at tick 7 (mid-bit), if sin_sync=1 it is a false start, return to IDLE with no write. Otherwise latch wls/pen/eps/stick_parity into frame registers and go to DATA.
  - Frame settings: input changes during a frame have no effect until the next start bit.
  - DATA: sample every 16 ticks, LSB first, wls+5 bits. Unreceived upper bits of d are 0. Go to PARITY if pen=1, else STOP.
  - PARITY: sample one bit. The expected bit depends on the settings:
    - stick_parity=0, eps=1: XOR of the received data bits.
    - stick_parity=0, eps=0: inverse of that XOR.
    - stick_parity=1: expected bit = ~eps.
    - pe=1 on mismatch.
  - STOP: sample at mid stop bit.
    - fe=1 if the stop bit is 0.
    - Only one stop bit is checked regardless of the stb setting.
    - Pulse rx_we_o for exactly one clk_i cycle, with rx_d_o valid in that cycle and held until the next write.
    - Go to IDLE, or to BRK_WAIT if break was detected.
- Break: if start, all data bits, parity (when enabled) and stop were all sampled 0, write bi=1, fe=1, pe=0, d=0x00.
- BRK_WAIT: stay until sin_sync=1 on a baud16_i cycle, then go to IDLE. No further writes occur while the line stays low.
- Re-arm: returning to IDLE at mid stop bit allows back-to-back frames with no idle gap.
- Latency: rx_we_o asserts on the cycle after the baud16_i cycle that samples the stop bit.
- busy_o is high from the START entry to the return to IDLE, including BRK_WAIT.
- Reset asserted mid-frame aborts the frame with no write and returns to the reset state.

Test Plan:
- 8N1, baud16_i tied to 1, frame 0xA5 (16 clocks/bit) -> exactly one rx_we_o pulse with rx_d_o=11'h0A5; busy_o low after.
- 7E1: 0x35 with parity bit 0, then again with parity bit 1 -> first write 11'h035; second write 11'h135 (pe=1).
- 5-bit, stick parity with eps=1, parity bit 0, stop=0, data 0x1F -> rx_d_o=11'h21F: d=0x1F, pe=0, fe=1, bi=0.
- Break: sin held low for 30 bit times (8N1) -> one write of 11'h600 and busy_o high until sin returns high. Next valid frame 0x3C -> 11'h03C.
- Glitch: sin low for 4 baud ticks, then high -> no write; busy_o returns to 0. A subsequent 0x55 is received correctly.
- Reset mid-data-bit 3 of 0xFF -> no write; outputs at reset values. Next frame 0x81 -> 11'h081.
